// File: rtl/my_rr_stream_arb.sv
// my_rr_stream_arb
//   Round-robin, packet-locked arbiter that merges NUM_SRC valid/ready streams
//   onto one registered output stream. A granted source keeps the grant until
//   its beat carrying i_last is accepted; the search for the next grant starts
//   one past the previously finished source.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_valid    per-source beat valid               [NUM_SRC]
//   i_last     per-source last beat of packet      [NUM_SRC]
//   i_data     per-source data, src k at [k*DW +: DW]
//   o_ready    per-source accept, one-hot or zero  [NUM_SRC]
//   o_valid    registered output beat valid
//   o_data     registered output data              [DW]
//   o_last     registered output last flag
//   o_src      source index of the current output beat [SW]
//   i_ready    downstream accept
//   o_busy     high while a packet grant is held
module my_rr_stream_arb #(
  parameter int DW      = 8,
  parameter int NUM_SRC = 4,
  parameter int SW      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_SRC-1:0]    i_valid,
  input  logic [NUM_SRC-1:0]    i_last,
  input  logic [NUM_SRC*DW-1:0] i_data,
  output logic [NUM_SRC-1:0]    o_ready,
  output logic                  o_valid,
  output logic [DW-1:0]         o_data,
  output logic                  o_last,
  output logic [SW-1:0]         o_src,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  localparam int unsigned NS = NUM_SRC;

  logic          state;
  logic [SW-1:0] grant;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant_nxt;
  logic          any_req;
  logic          out_free;
  logic          accept;
  logic [DW-1:0] sel_data;

  // Rotating priority search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    any_req   = 1'b0;
    grant_nxt = grant;
    for (int unsigned k = 0; k < NS; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NS) idx = idx - NS;
      if (!any_req && i_valid[idx[SW-1:0]]) begin
        any_req   = 1'b1;
        grant_nxt = idx[SW-1:0];
      end
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign out_free = !o_valid || i_ready;
  assign accept   = (state == ST_LOCK) && i_valid[grant] && out_free;
  assign sel_data = i_data[32'(grant)*DW +: DW];
  assign o_busy   = (state == ST_LOCK);

  always_comb begin
    o_ready = '0;
    if (state == ST_LOCK) o_ready[grant] = out_free;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= grant_nxt;
            state <= ST_LOCK;
          end
        end
        default: begin
          if (accept && i_last[grant]) begin
            state  <= ST_IDLE;
            rr_ptr <= (grant == SW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_src   <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= sel_data;
      o_last  <= i_last[grant];
      o_src   <= grant;
    end else if (out_free) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_my_rr_stream_arb.sv
module tb_my_rr_stream_arb;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
    logic [1:0] src;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_valid;
  logic [3:0]  i_last;
  logic [31:0] i_data;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic [1:0]  o_src;
  logic        i_ready;
  logic        o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t      sb[$];
  logic [8:0] srcq[4][$];
  logic [3:0] acc;

  my_rr_stream_arb #(.DW(8), .NUM_SRC(4), .SW(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_last(i_last),
    .i_data(i_data), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .o_src(o_src), .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every downstream handshake pops one expected beat.
  initial begin
    beat_t got, want;
    forever begin
      @(negedge i_clk);
      if (i_reset_n && o_valid && i_ready) begin
        got = '{last: o_last, data: o_data, src: o_src};
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL beat_unexpected: got %0h expected none", got);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL beat: got last=%0b data=%0h src=%0d expected last=%0b data=%0h src=%0d",
                     got.last, got.data, got.src, want.last, want.data, want.src);
          end
        end
      end
    end
  end

  task automatic drive_srcs();
    for (int k = 0; k < 4; k++) begin
      if (srcq[k].size() > 0) begin
        i_valid[k]         = 1'b1;
        i_last[k]          = srcq[k][0][8];
        i_data[k*8 +: 8]   = srcq[k][0][7:0];
      end else begin
        i_valid[k]         = 1'b0;
        i_last[k]          = 1'b0;
        i_data[k*8 +: 8]   = 8'h00;
      end
    end
  endtask

  task automatic put(input int s, input logic last, input logic [7:0] d);
    srcq[s].push_back({last, d});
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic last, input logic [1:0] s);
    sb.push_back('{last: last, data: d, src: s});
  endtask

  // One clock: note which sources handshake, then advance their queues.
  task automatic step();
    @(negedge i_clk);
    acc = i_valid & o_ready;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (acc[k]) void'(srcq[k].pop_front());
    drive_srcs();
  endtask

  function automatic logic srcs_empty();
    return (srcq[0].size() == 0) && (srcq[1].size() == 0) &&
           (srcq[2].size() == 0) && (srcq[3].size() == 0);
  endfunction

  task automatic drain(input string nm);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !o_valid && srcs_empty()) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({nm, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset_n = 1'b0;
    i_ready   = 1'b1;
    i_valid   = '0;
    i_last    = '0;
    i_data    = '0;

    // Reset held with every source requesting; fairness packets preloaded.
    for (int k = 0; k < 4; k++) put(k, 1'b1, 8'(8'h10 + k));
    for (int k = 0; k < 4; k++) put(k, 1'b1, 8'(8'h20 + k));
    drive_srcs();
    repeat (2) step();
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_ready", {28'd0, o_ready}, 32'd0);
    chk("rst_o_data",  {24'd0, o_data},  32'd0);
    chk("rst_o_src",   {30'd0, o_src},   32'd0);
    chk("rst_o_busy",  {31'd0, o_busy},  32'd0);

    // Fairness: 1-beat packets rotate 0,1,2,3 with one idle cycle between beats.
    expect_beat(8'h10, 1'b1, 2'd0); expect_beat(8'h11, 1'b1, 2'd1);
    expect_beat(8'h12, 1'b1, 2'd2); expect_beat(8'h13, 1'b1, 2'd3);
    expect_beat(8'h20, 1'b1, 2'd0); expect_beat(8'h21, 1'b1, 2'd1);
    expect_beat(8'h22, 1'b1, 2'd2); expect_beat(8'h23, 1'b1, 2'd3);
    i_reset_n = 1'b1;
    step();
    chk("grant0_busy",  {31'd0, o_busy},  32'd1);
    chk("grant0_ready", {28'd0, o_ready}, 32'h1);
    for (int n = 2; n <= 17; n++) begin
      step();
      chk($sformatf("fair_valid_c%0d", n), {31'd0, o_valid},
          {31'd0, ((n % 2) == 0) && (n <= 16)});
    end
    drain("fair");

    // Packet lock: src1 3 beats while src2 waits; rr_ptr is 0 here.
    put(1, 1'b0, 8'hA1); put(1, 1'b0, 8'hA2); put(1, 1'b1, 8'hA3);
    put(2, 1'b1, 8'hB1);
    expect_beat(8'hA1, 1'b0, 2'd1); expect_beat(8'hA2, 1'b0, 2'd1);
    expect_beat(8'hA3, 1'b1, 2'd1); expect_beat(8'hB1, 1'b1, 2'd2);
    drive_srcs();
    drain("lock");

    // Backpressure: src0 4 beats, stall 5 cycles while C2 sits on the output.
    put(0, 1'b0, 8'hC1); put(0, 1'b0, 8'hC2); put(0, 1'b0, 8'hC3); put(0, 1'b1, 8'hC4);
    expect_beat(8'hC1, 1'b0, 2'd0); expect_beat(8'hC2, 1'b0, 2'd0);
    expect_beat(8'hC3, 1'b0, 2'd0); expect_beat(8'hC4, 1'b1, 2'd0);
    drive_srcs();
    repeat (3) step();
    i_ready = 1'b0;
    #1;
    for (int c = 0; c <= 5; c++) begin
      chk($sformatf("bp_valid_%0d", c), {31'd0, o_valid}, 32'd1);
      chk($sformatf("bp_data_%0d", c),  {24'd0, o_data},  32'hC2);
      chk($sformatf("bp_last_%0d", c),  {31'd0, o_last},  32'd0);
      chk($sformatf("bp_src_%0d", c),   {30'd0, o_src},   32'd0);
      chk($sformatf("bp_ready_%0d", c), {28'd0, o_ready}, 32'd0);
      if (c < 5) step();
    end
    i_ready = 1'b1;
    drain("bp");

    // Wrap/skip: src2 moves rr_ptr to 3; lone src1 wins; then src3 beats src0.
    put(2, 1'b1, 8'hD2);
    expect_beat(8'hD2, 1'b1, 2'd2);
    drive_srcs();
    drain("wrap_a");
    put(1, 1'b1, 8'hE1);
    expect_beat(8'hE1, 1'b1, 2'd1);
    drive_srcs();
    drain("wrap_b");
    put(3, 1'b1, 8'hF3);
    put(0, 1'b1, 8'hF0);
    expect_beat(8'hF3, 1'b1, 2'd3); expect_beat(8'hF0, 1'b1, 2'd0);
    drive_srcs();
    drain("wrap_c");

    // Async reset during beat 2 of 4 on src3: only G1 ever leaves.
    put(3, 1'b0, 8'h31); put(3, 1'b0, 8'h32); put(3, 1'b0, 8'h33); put(3, 1'b1, 8'h34);
    expect_beat(8'h31, 1'b0, 2'd3);
    drive_srcs();
    repeat (3) step();
    chk("pre_rst_data", {24'd0, o_data}, 32'h32);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("arst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_o_ready", {28'd0, o_ready}, 32'd0);
    chk("arst_o_data",  {24'd0, o_data},  32'd0);
    chk("arst_o_src",   {30'd0, o_src},   32'd0);
    chk("arst_o_busy",  {31'd0, o_busy},  32'd0);
    for (int k = 0; k < 4; k++) srcq[k].delete();
    drive_srcs();
    repeat (2) step();
    i_reset_n = 1'b1;
    put(2, 1'b0, 8'h51); put(2, 1'b1, 8'h52);
    expect_beat(8'h51, 1'b0, 2'd2); expect_beat(8'h52, 1'b1, 2'd2);
    drive_srcs();
    step();
    chk("post_rst_busy",  {31'd0, o_busy},  32'd1);
    chk("post_rst_ready", {28'd0, o_ready}, 32'h4);
    drain("post_rst");

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
